lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width; only DW=32 is supported.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 mem_en  in  1  memory-access request from controller, level-sensitive.
REQ-006 is_mem_load  in  1  current instruction is a load.
REQ-007 is_mem_store  in  1  current instruction is a store.
REQ-008 func3  in  3  access size/sign (RV32I encoding).
REQ-009 addr  in  AW  effective byte address (ALU result).
REQ-010 wdata  in  DW  store data (rs2).
REQ-011 stall  out  1  holds PC/pipeline while access is in flight.
REQ-012 ld_data  out  DW  formatted load result, to rd write-back mux (RD_MEM path).
REQ-013 ld_valid  out  1  one-cycle pulse; ld_data valid, rf write permitted.
REQ-014 err  out  1  one-cycle pulse; misaligned or illegal access, no bus cycle.
REQ-015 dmem_req  out  1  bus request.
REQ-016 dmem_we  out  1  1 = write.
REQ-017 dmem_addr  out  AW  word-aligned address (addr[1:0] forced to 0).
REQ-018 dmem_wdata  out  DW  lane-replicated store data.
REQ-019 dmem_be  out  4  byte enables.
REQ-020 dmem_gnt  in  1  bus accepts request this cycle.
REQ-021 dmem_rvalid  in  1  read data valid this cycle.
REQ-022 dmem_rdata  in  DW  read data word.

Function
REQ-023 FSM states IDLE, REQ, WAIT, DONE; registered state.
REQ-024 IDLE: access accepted when mem_en=1, exactly one of is_mem_load/is_mem_store=1, func3 legal, address aligned; latch addr, func3, wdata, direction; next REQ.
REQ-025 Legal func3: load 0,1,2,4,5; store 0,1,2. Aligned: half needs addr[0]=0; word needs addr[1:0]=0.
REQ-026 IDLE with mem_en=1 but not accepted: err=1 for that cycle, no bus request, remain IDLE; ld_valid stays 0.
REQ-027 stall=1 combinationally in IDLE on accept cycle, and throughout REQ and WAIT; stall=0 in DONE and otherwise.
REQ-028 REQ: dmem_req=1; dmem_we, dmem_addr, dmem_wdata, dmem_be driven from latched values and held stable until dmem_gnt=1.
REQ-029 REQ with dmem_gnt=1: store -> DONE; load -> WAIT. dmem_rvalid in the same cycle as gnt is ignored.
REQ-030 WAIT: dmem_req=0; on dmem_rvalid=1 register formatted data into ld_data, -> DONE.
REQ-031 DONE: ld_valid=1 iff access was a load; -> IDLE unconditionally; mem_en ignored in DONE.
REQ-032 Store byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111. dmem_wdata: SB byte replicated x4, SH half replicated x2, SW as-is.
REQ-033 Load formatting selects lane by latched addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
REQ-034 ld_data holds its last value until the next load completes.
REQ-035 Minimum latency: store 3 cycles accept-to-DONE exit (gnt first REQ cycle); load 4 cycles (gnt and rvalid each on first opportunity).
REQ-036 dmem_req, ld_valid, err never asserted in the same cycle as each other.

Reset
REQ-037 rst_n=0 asynchronously forces IDLE; dmem_req, dmem_we, stall, ld_valid, err = 0; dmem_be=0; dmem_addr, dmem_wdata, ld_data = 0.
REQ-038 Reset in REQ or WAIT abandons the access; rvalid after reset release while in IDLE is ignored.

Verification
REQ-039 LW addr=0x100, rdata=0x8000_00F0, gnt cycle 1, rvalid cycle 2 -> dmem_addr=0x100, be=4'hF, ld_data=0x8000_00F0, ld_valid pulse 1 cycle, stall high 3 cycles.
REQ-040 LB addr=0x103, rdata=0x80AA_BBCC -> ld_data=0xFFFF_FF80; LBU same -> 0x0000_0080; LHU addr=0x102 -> 0x0000_80AA.
REQ-041 SH addr=0x202, wdata=0x1234_5678, gnt held low 3 cycles -> dmem_req high 4 cycles with be=4'b1100, wdata=0x5678_5678, dmem_we=1 stable; no ld_valid.
REQ-042 LW addr=0x101 -> err pulse, dmem_req never asserts, stall=0; SB with func3=3 -> err.
REQ-043 rst_n low during WAIT, rvalid asserted after release -> outputs zero, state IDLE, no ld_valid.
REQ-044 Back-to-back: store then load with mem_en held high -> second access accepted the cycle after DONE, no overlap of dmem_req.

Source files
------------

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit with a single-outstanding data-memory bus FSM
module lsu #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mem_en,
    input  logic          is_mem_load,
    input  logic          is_mem_store,
    input  logic [2:0]    func3,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          stall,
    output logic [DW-1:0] ld_data,
    output logic          ld_valid,
    output logic          err,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    output logic [3:0]    dmem_be,
    input  logic          dmem_gnt,
    input  logic          dmem_rvalid,
    input  logic [DW-1:0] dmem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic          we_q;
    logic [2:0]    func3_q;
    logic [1:0]    off_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [3:0]    be_q;

    logic          one_dir;
    logic          f3_legal;
    logic          aligned;
    logic          accept;
    logic [3:0]    be_new;
    logic [DW-1:0] wdata_new;
    logic [DW-1:0] ld_fmt;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;

    // Decode legality/alignment of the presented access and build its bus lanes
    always_comb begin
        one_dir  = is_mem_load ^ is_mem_store;
        if (is_mem_load) begin
            f3_legal = (func3 != 3'd3) && (func3 != 3'd6) && (func3 != 3'd7);
        end else begin
            f3_legal = (func3 <= 3'd2);
        end
        case (func3[1:0])
            2'd1:    aligned = ~addr[0];
            2'd2:    aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        accept = (state_q == S_IDLE) && mem_en && one_dir && f3_legal && aligned;
        case (func3[1:0])
            2'd0: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            2'd1: begin
                be_new    = 4'b0011 << addr[1:0];
                wdata_new = {2{wdata[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = wdata;
            end
        endcase
    end

    // Pick the addressed byte/half lane of the read word and extend it
    always_comb begin
        case (off_q)
            2'd0:    lane_b = dmem_rdata[7:0];
            2'd1:    lane_b = dmem_rdata[15:8];
            2'd2:    lane_b = dmem_rdata[23:16];
            default: lane_b = dmem_rdata[31:24];
        endcase
        lane_h = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (func3_q)
            3'd0:    ld_fmt = {{(DW-8){lane_b[7]}}, lane_b};
            3'd1:    ld_fmt = {{(DW-16){lane_h[15]}}, lane_h};
            3'd4:    ld_fmt = {{(DW-8){1'b0}}, lane_b};
            3'd5:    ld_fmt = {{(DW-16){1'b0}}, lane_h};
            default: ld_fmt = dmem_rdata;
        endcase
    end

    // Next-state and per-state control outputs
    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        err      = 1'b0;
        dmem_req = 1'b0;
        ld_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_en) begin
                    if (accept) begin
                        stall   = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            S_REQ: begin
                stall    = 1'b1;
                dmem_req = 1'b1;
                if (dmem_gnt) begin
                    state_d = we_q ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (dmem_rvalid) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                ld_valid = ~we_q;
                state_d  = S_IDLE;
            end
        endcase
    end

    // State register, access latch on accept, and load-result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            func3_q <= 3'd0;
            off_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'd0;
            ld_data <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= is_mem_store;
                func3_q <= func3;
                off_q   <= addr[1:0];
                addr_q  <= {addr[AW-1:2], 2'b00};
                wdata_q <= wdata_new;
                be_q    <= be_new;
            end
            if (state_q == S_WAIT && dmem_rvalid) begin
                ld_data <= ld_fmt;
            end
        end
    end

    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - scoreboard bench for lsu
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_en = 1'b0;
    logic        is_mem_load = 1'b0;
    logic        is_mem_store = 1'b0;
    logic [2:0]  func3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;

    lsu #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .is_mem_load(is_mem_load),
        .is_mem_store(is_mem_store), .func3(func3), .addr(addr), .wdata(wdata),
        .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid), .err(err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic        is_err;
        logic [31:0] data;
    } resp_t;

    bus_t  bus_q[$];
    resp_t resp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    req_cycles = 0;
    int    stall_cycles = 0;
    int    ldv_cycles = 0;
    int    sc, rc, lc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a bus beat or a response
    always @(negedge clk) begin
        bus_t  b;
        resp_t r;
        if (dmem_req) req_cycles++;
        if (stall) stall_cycles++;
        if (ld_valid) ldv_cycles++;
        if (dmem_req || ld_valid || err)
            check("one_hot", 32'(dmem_req) + 32'(ld_valid) + 32'(err), 32'd1);
        if (dmem_req && dmem_gnt) begin
            if (bus_q.size() == 0) unexpected("bus_beat");
            else begin
                b = bus_q.pop_front();
                check("bus_we", 32'(dmem_we), 32'(b.we));
                check("bus_addr", dmem_addr, b.addr);
                check("bus_be", 32'(dmem_be), 32'(b.be));
                if (b.we) check("bus_wdata", dmem_wdata, b.wdata);
            end
        end
        if (ld_valid || err) begin
            if (resp_q.size() == 0) unexpected(ld_valid ? "ld_valid" : "err");
            else begin
                r = resp_q.pop_front();
                check("resp_kind", 32'(err), 32'(r.is_err));
                if (ld_valid) check("ld_data", ld_data, r.data);
            end
        end
    end

    task automatic access(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                          input logic [31:0] rd, input logic rv_on_gnt, input bus_t eb,
                          input logic [31:0] exp_ld);
        bus_q.push_back(eb);
        if (ld) resp_q.push_back('{1'b0, exp_ld});
        @(posedge clk); #1;
        mem_en = 1'b1; is_mem_load = ld; is_mem_store = ~ld;
        func3 = f3; addr = a; wdata = wd;
        @(negedge clk) check("stall_accept", 32'(stall), 32'd1);
        @(posedge clk); #1;
        mem_en = 1'b0; is_mem_load = 1'b0; is_mem_store = 1'b0;
        for (int i = 0; i < gnt_dly; i++) begin
            @(negedge clk);
            check("hold_req", 32'(dmem_req), 32'd1);
            check("hold_we", 32'(dmem_we), 32'(eb.we));
            check("hold_addr", dmem_addr, eb.addr);
            check("hold_be", 32'(dmem_be), 32'(eb.be));
            @(posedge clk); #1;
        end
        dmem_gnt = 1'b1;
        if (rv_on_gnt) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = 32'hDEAD_0000;
        end
        @(posedge clk); #1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        if (ld) begin
            for (int i = 0; i < rv_dly; i++) begin
                @(negedge clk) check("wait_no_req", 32'(dmem_req), 32'd0);
                @(posedge clk); #1;
            end
            dmem_rvalid = 1'b1; dmem_rdata = rd;
            @(posedge clk); #1;
            dmem_rvalid = 1'b0;
        end
        @(negedge clk) check("stall_done", 32'(stall), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic bad_access(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a);
        resp_q.push_back('{1'b1, 32'd0});
        @(posedge clk); #1;
        mem_en = 1'b1; is_mem_load = ld; is_mem_store = st; func3 = f3; addr = a;
        @(negedge clk);
        check("err_stall", 32'(stall), 32'd0);
        check("err_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        mem_en = 1'b0; is_mem_load = 1'b0; is_mem_store = 1'b0;
        @(negedge clk) check("err_req_after", 32'(dmem_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_ld_data", ld_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // LW with stray rvalid on the grant cycle
        sc = stall_cycles; lc = ldv_cycles;
        access(1'b1, 3'd2, 32'h100, 32'd0, 0, 0, 32'h8000_00F0, 1'b1,
               '{1'b0, 32'h100, 4'hF, 32'd0}, 32'h8000_00F0);
        check("lw_stall_cycles", 32'(stall_cycles - sc), 32'd3);
        check("lw_ldv_cycles", 32'(ldv_cycles - lc), 32'd1);

        access(1'b1, 3'd0, 32'h103, 32'd0, 1, 2, 32'h80AA_BBCC, 1'b0,
               '{1'b0, 32'h100, 4'b1000, 32'd0}, 32'hFFFF_FF80);
        access(1'b1, 3'd4, 32'h103, 32'd0, 0, 0, 32'h80AA_BBCC, 1'b0,
               '{1'b0, 32'h100, 4'b1000, 32'd0}, 32'h0000_0080);
        access(1'b1, 3'd5, 32'h102, 32'd0, 0, 1, 32'h80AA_BBCC, 1'b0,
               '{1'b0, 32'h100, 4'b1100, 32'd0}, 32'h0000_80AA);
        access(1'b1, 3'd1, 32'h102, 32'd0, 0, 0, 32'h80AA_BBCC, 1'b0,
               '{1'b0, 32'h100, 4'b1100, 32'd0}, 32'hFFFF_80AA);
        access(1'b1, 3'd0, 32'h100, 32'd0, 0, 0, 32'h80AA_BBCC, 1'b0,
               '{1'b0, 32'h100, 4'b0001, 32'd0}, 32'hFFFF_FFCC);
        access(1'b1, 3'd4, 32'h101, 32'd0, 0, 0, 32'h80AA_BBCC, 1'b0,
               '{1'b0, 32'h100, 4'b0010, 32'd0}, 32'h0000_00BB);

        // SH with grant withheld for three cycles
        rc = req_cycles; lc = ldv_cycles;
        access(1'b0, 3'd1, 32'h202, 32'h1234_5678, 3, 0, 32'd0, 1'b0,
               '{1'b1, 32'h200, 4'b1100, 32'h5678_5678}, 32'd0);
        check("sh_req_cycles", 32'(req_cycles - rc), 32'd4);
        check("sh_no_ldv", 32'(ldv_cycles - lc), 32'd0);
        check("ld_data_held", ld_data, 32'h0000_00BB);

        access(1'b0, 3'd0, 32'h201, 32'h0000_00EF, 0, 0, 32'd0, 1'b0,
               '{1'b1, 32'h200, 4'b0010, 32'hEFEF_EFEF}, 32'd0);

        // Illegal and misaligned requests
        rc = req_cycles;
        bad_access(1'b1, 1'b0, 3'd2, 32'h101);
        bad_access(1'b0, 1'b1, 3'd3, 32'h200);
        bad_access(1'b1, 1'b0, 3'd1, 32'h101);
        bad_access(1'b1, 1'b1, 3'd2, 32'h100);
        check("err_no_req", 32'(req_cycles - rc), 32'd0);

        // Reset while waiting for read data, rvalid after release
        bus_q.push_back('{1'b0, 32'h300, 4'hF, 32'd0});
        lc = ldv_cycles;
        @(posedge clk); #1;
        mem_en = 1'b1; is_mem_load = 1'b1; func3 = 3'd2; addr = 32'h300;
        @(posedge clk); #1;
        mem_en = 1'b0; is_mem_load = 1'b0; dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("wrst_stall", 32'(stall), 32'd0);
        check("wrst_req", 32'(dmem_req), 32'd0);
        check("wrst_addr", dmem_addr, 32'd0);
        check("wrst_be", 32'(dmem_be), 32'd0);
        check("wrst_ld_data", ld_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        check("wrst_stall_after", 32'(stall), 32'd0);
        check("wrst_ld_after", ld_data, 32'd0);
        @(posedge clk); #1;
        check("wrst_no_ldv", 32'(ldv_cycles - lc), 32'd0);

        // Back-to-back store then load with mem_en held high
        bus_q.push_back('{1'b1, 32'h400, 4'hF, 32'hDEAD_BEEF});
        bus_q.push_back('{1'b0, 32'h404, 4'hF, 32'd0});
        resp_q.push_back('{1'b0, 32'hCAFE_F00D});
        @(posedge clk); #1;
        mem_en = 1'b1; is_mem_store = 1'b1; func3 = 3'd2; addr = 32'h400; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0; is_mem_store = 1'b0; is_mem_load = 1'b1; addr = 32'h404;
        @(negedge clk);
        check("b2b_done_stall", 32'(stall), 32'd0);
        check("b2b_done_req", 32'(dmem_req), 32'd0);
        check("b2b_done_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_accept_stall", 32'(stall), 32'd1);
        check("b2b_accept_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        mem_en = 1'b0; is_mem_load = 1'b0; dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bus_q_empty", 32'(bus_q.size()), 32'd0);
        check("resp_q_empty", 32'(resp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
